// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue logic: request opcodes, idle md_op
// encoding, FSM state type and opcode class helpers.
package md_pkg;

    localparam logic [2:0] OP_MULT    = 3'b000;
    localparam logic [2:0] OP_MULTU   = 3'b001;
    localparam logic [2:0] OP_DIV     = 3'b010;
    localparam logic [2:0] OP_DIVU    = 3'b011;
    localparam logic [2:0] OP_MTHI    = 3'b100;
    localparam logic [2:0] OP_MTLO    = 3'b101;
    localparam logic [2:0] OP_MFHI    = 3'b110;
    localparam logic [2:0] OP_MFLO    = 3'b111;

    localparam logic [2:0] MD_OP_IDLE = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return ~op[2];
    endfunction

    function automatic logic is_mt(input logic [2:0] op);
        return (op[2:1] == 2'b10);
    endfunction

    function automatic logic is_mf(input logic [2:0] op);
        return (op[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Latency down-counter for md operations: loadable, decrements while enabled, never
// wraps below zero, and flags the zero state.
module md_lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_value,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_value = r_cnt;
    assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/md_issue.sv
// Multiply/divide issue stage: accepts HI/LO-class requests, drives md, times mult/div
// itself and returns mfhi/mflo data. Optional MD_FLUSH_EN adds a flush input.
module md_issue
    import md_pkg::*;
#(
    parameter int W       = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         stall,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_data,
    output logic         md_start,
    output logic [2:0]   md_op,
    output logic [W-1:0] md_data1,
    output logic [W-1:0] md_data2,
    input  logic         md_busy,
    input  logic [W-1:0] md_hi,
    input  logic [W-1:0] md_lo
`ifdef MD_FLUSH_EN
   ,input  logic         flush
`endif
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_state_e        r_state;
    logic             r_md_start;
    logic [2:0]       r_md_op;
    logic [W-1:0]     r_md_data1;
    logic [W-1:0]     r_md_data2;
    logic             r_rsp_valid;
    logic [W-1:0]     r_rsp_data;

    logic             w_flush;
    logic             w_busy_eff;
    logic             w_accept;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_zero;
    logic             w_req_mf;

`ifdef MD_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // md_start covers the cycle where md has not yet raised md_busy for a fresh Start.
    assign w_busy_eff = (r_state == ST_BUSY) | md_busy | r_md_start;
    assign w_req_mf   = is_mf(req_op);

    // An mf* right behind an mt* waits one cycle so md has latched the write.
    assign req_ready  = ~w_busy_eff & ~(w_req_mf & is_mt(r_md_op)) & ~w_flush;
    assign stall      = req_valid & ~req_ready;
    assign w_accept   = req_valid & req_ready;
    assign w_load     = w_accept & is_muldiv(req_op);
    assign w_load_val = req_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

    md_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (r_state == ST_BUSY),
        .o_value    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_md_start  <= 1'b0;
            r_md_op     <= MD_OP_IDLE;
            r_md_data1  <= '0;
            r_md_data2  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_md_start  <= w_load;
            r_md_op     <= (w_accept & ~w_req_mf) ? req_op : MD_OP_IDLE;
            r_rsp_valid <= w_accept & w_req_mf & ~w_flush;

            if (w_accept & ~w_req_mf) begin
                r_md_data1 <= req_a;
            end
            if (w_load) begin
                r_md_data2 <= req_b;
            end
            if (w_accept & w_req_mf) begin
                r_rsp_data <= req_op[0] ? md_lo : md_hi;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if ((w_cnt == CNT_W'(1)) || w_cnt_zero) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign md_start  = r_md_start;
    assign md_op     = r_md_op;
    assign md_data1  = r_md_data1;
    assign md_data2  = r_md_data2;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_md_issue.sv
// Bench for md_issue: directed scenarios plus random traffic against an architectural
// HI/LO model and a simple md unit model. MD_FLUSH_EN enables the flush scenarios.
module tb_md_issue;

    localparam int W       = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_op = 3'b111;
    logic [W-1:0]  req_a = '0;
    logic [W-1:0]  req_b = '0;
    logic          stall;
    logic          rsp_valid;
    logic [W-1:0]  rsp_data;
    logic          md_start;
    logic [2:0]    md_op;
    logic [W-1:0]  md_data1;
    logic [W-1:0]  md_data2;
    logic          md_busy = 1'b0;
    logic [W-1:0]  md_hi = '0;
    logic [W-1:0]  md_lo = '0;
`ifdef MD_FLUSH_EN
    logic          flush = 1'b0;
`endif

    md_issue #(.W(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_data1  (md_data1),
        .md_data2  (md_data2),
        .md_busy   (md_busy),
        .md_hi     (md_hi),
        .md_lo     (md_lo)
`ifdef MD_FLUSH_EN
       ,.flush     (flush)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {HI, LO} result of a mult/div class op
    function automatic logic [63:0] md_math(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin
                sp = 64'(sa) * 64'(sb);
                return sp;
            end
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: return {32'(sa % sb), 32'(sa / sb)};
            3'd3: return {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    // reference model state
    int          cyc = 0;
    int          free_cyc = 0;
    bit          mt_pend = 0;
    bit          outs_known = 0;
    bit          last_rst = 0;
    bit          rand_busy_en = 0;
    logic        e_start = 0;
    logic [2:0]  e_op = 3'b111;
    logic [31:0] e_d1 = 0, e_d2 = 0, e_rsp = 0;
    logic        e_rv = 0;
    logic [31:0] arch_hi = 0, arch_lo = 0;
    int          md_bcnt = 0;
    logic        obs_rsp_v, obs_ready;
    logic [31:0] obs_rsp_d, obs_d1;
    logic [2:0]  obs_md_op;
    logic        obs_start;

    task automatic step(input bit rst, input bit v, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input bit fl,
                        output bit acc);
        logic        start_s;
        logic [2:0]  op_s;
        logic [31:0] d1_s, d2_s;
        logic [63:0] r;
        bit          exp_rdy;
        @(negedge clk);
        start_s = md_start; op_s = md_op; d1_s = md_data1; d2_s = md_data2;
        obs_rsp_v = rsp_valid; obs_rsp_d = rsp_data; obs_md_op = md_op;
        obs_start = md_start; obs_d1 = md_data1;
        if (outs_known) begin
            chk("md_start", start_s, e_start);
            chk("md_op", op_s, e_op);
            if (e_start) chk("md_data2", d2_s, e_d2);
            if (e_start || e_op == 3'd4 || e_op == 3'd5) chk("md_data1", d1_s, e_d1);
            chk("rsp_valid", obs_rsp_v, e_rv);
            if (e_rv) chk("rsp_data", obs_rsp_d, e_rsp);
        end
        // md unit: result becomes visible right after it sees Start or an mt write
        if (last_rst) begin
            md_bcnt = 0;
        end else if (outs_known) begin
            if (start_s === 1'b1) begin
                r = md_math(op_s, d1_s, d2_s);
                md_hi = r[63:32];
                md_lo = r[31:0];
                md_bcnt = 3;
            end else if (op_s === 3'd4) begin
                md_hi = d1_s;
            end else if (op_s === 3'd5) begin
                md_lo = d1_s;
            end
        end
        md_busy = (md_bcnt > 0) || (rand_busy_en && $urandom_range(0, 9) == 0);
        if (md_bcnt > 0) md_bcnt--;
        reset = rst; req_valid = v; req_op = op; req_a = a; req_b = b;
`ifdef MD_FLUSH_EN
        flush = fl;
`endif
        #1;
        obs_ready = req_ready;
        acc = ((req_valid & req_ready) === 1'b1);
        if (outs_known && !rst) begin
            exp_rdy = (cyc >= free_cyc) && !md_busy && !(op[2:1] == 2'b11 && mt_pend) && !fl;
            chk("req_ready", req_ready, exp_rdy);
            chk("stall", stall, v && !exp_rdy);
        end
        @(posedge clk);
        last_rst = rst;
        if (rst) begin
            outs_known = 1; e_start = 0; e_op = 3'b111; e_d1 = 0; e_d2 = 0;
            e_rv = 0; free_cyc = 0; mt_pend = 0;
        end else begin
            e_start = acc && !op[2];
            e_op    = (acc && op[2:1] != 2'b11) ? op : 3'b111;
            e_rv    = acc && op[2:1] == 2'b11 && !fl;
            mt_pend = acc && op[2:1] == 2'b10;
            if (acc) begin
                if (op[2:1] != 2'b11) e_d1 = a;
                if (!op[2]) e_d2 = b;
                case (op)
                    3'd6: e_rsp = arch_hi;
                    3'd7: e_rsp = arch_lo;
                    3'd4: arch_hi = a;
                    3'd5: arch_lo = a;
                    default: begin
                        {arch_hi, arch_lo} = md_math(op, a, b);
                        free_cyc = cyc + (op[1] ? DIV_LAT : MUL_LAT) + 1;
                    end
                endcase
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(0, 0, 3'd7, 0, 0, 0, acc);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
        bit acc;
        stalls = 0;
        for (int k = 0; k < 40; k++) begin
            step(0, 1, op, a, b, 0, acc);
            if (acc) return;
            stalls++;
        end
        chk("issue_timeout", 1, 0);
    endtask

    initial begin
        int  s;
        bit  acc;
        logic [2:0]  op;
        logic [31:0] a, b;

        // reset and idle outputs
        step(1, 0, 3'd7, 0, 0, 0, acc);
        step(1, 0, 3'd7, 0, 0, 0, acc);
        step(0, 0, 3'd7, 0, 0, 0, acc);
        chk("t1_md_op", obs_md_op, 3'b111);
        chk("t1_md_start", obs_start, 0);
        chk("t1_ready", obs_ready, 1);
        chk("t1_rsp_valid", obs_rsp_v, 0);
        chk("t1_md_data1", obs_d1, 0);

        // signed multiply, then read back LO and HI
        issue(3'd0, 32'd3, 32'hFFFF_FFFC, s);
        issue(3'd7, 0, 0, s);
        chk("t2_mflo_stall", s, 5);
        issue(3'd6, 0, 0, s);
        chk("t2_mfhi_stall", s, 0);
        chk("t2_lo", obs_rsp_d, 32'hFFFF_FFF4);
        idle(1);
        chk("t2_hi", obs_rsp_d, 32'hFFFF_FFFF);

        // back-to-back divides
        issue(3'd2, 32'd7, 32'd2, s);
        issue(3'd3, 32'd9, 32'd4, s);
        chk("t3_divu_stall", s, 10);
        issue(3'd7, 0, 0, s);
        chk("t3_mflo_stall", s, 10);
        issue(3'd6, 0, 0, s);
        chk("t3_divu_lo", obs_rsp_d, 2);
        idle(1);
        chk("t3_divu_hi", obs_rsp_d, 1);
        issue(3'd2, 32'd7, 32'd2, s);
        issue(3'd7, 0, 0, s);
        issue(3'd6, 0, 0, s);
        chk("t3_div_lo", obs_rsp_d, 3);
        idle(1);
        chk("t3_div_hi", obs_rsp_d, 1);

        // mt write followed immediately by a read
        issue(3'd4, 32'hDEAD_BEEF, 0, s);
        issue(3'd6, 0, 0, s);
        chk("t4_mfhi_stall", s, 1);
        idle(1);
        chk("t4_hi", obs_rsp_d, 32'hDEAD_BEEF);

        // reset in the third busy cycle of a divide
        issue(3'd2, 32'd100, 32'd7, s);
        idle(2);
        step(1, 0, 3'd7, 0, 0, 0, acc);
        step(0, 0, 3'd7, 0, 0, 0, acc);
        chk("t5_ready", obs_ready, 1);
        chk("t5_rsp_valid", obs_rsp_v, 0);
        chk("t5_md_op", obs_md_op, 3'b111);

`ifdef MD_FLUSH_EN
        step(0, 1, 3'd7, 0, 0, 1, acc);
        chk("t6_flush_acc", acc, 0);
        idle(1);
        chk("t6_flush_rsp", obs_rsp_v, 0);
        issue(3'd0, 32'd5, 32'd6, s);
        for (int k = 0; k < 3; k++) step(0, 0, 3'd7, 0, 0, 1, acc);
        issue(3'd7, 0, 0, s);
        chk("t6_busy_flush_stall", s, 2);
        idle(1);
        chk("t6_lo", obs_rsp_d, 30);
`endif

        // randomized traffic
        rand_busy_en = 1;
        for (int k = 0; k < 1500; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if (op[2:1] == 2'b01 && (b == 0 || b == 32'hFFFF_FFFF)) b = 32'd1;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, op, a, b,
`ifdef MD_FLUSH_EN
                 $urandom_range(0, 9) == 0,
`else
                 1'b0,
`endif
                 acc);
        end
        rand_busy_en = 0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
